adc_trigger_sequencer: RTL
==========================

Name: adc_trigger_sequencer

Overview:
Sample-clock-domain trigger and segment sequencer. It consumes the arm, trigger-mode, offset and segment settings produced by the ADC register block. It detects the qualified trigger event, applies the trigger offset, and issues one capture-start pulse per segment to the FIFO/capture logic. It also measures trigger-active duration and returns it to the register block as trigger_length.

Parameters:
pSEG_W, 16, width of num_segments and of the segment counter
pCYC_W, 20, width of segment_cycles and of the inter-segment counter

Ports:
adc_sampleclk  in  1  sole clock; all logic on its rising edge
reset_i  in  1  synchronous, active-high reset
cmd_arm_adc  in  1  arm level, already synchronised to adc_sampleclk
trig_in  in  1  raw trigger level, already synchronous to adc_sampleclk
trigger_mode  in  1  1 = active-high/rising, 0 = active-low/falling
trigger_wait  in  1  1 = trigger must be seen inactive before arming completes
trigger_now  in  1  force a trigger event, level input; its 0->1 edge is used
trigger_offset  in  32  cycles between trigger event and capture start
num_segments  in  pSEG_W  segments per arm; 0 is treated as 1
segment_cycles  in  pCYC_W  inter-segment spacing in counter mode; 0 is treated as 1
segment_cycle_counter_en  in  1  1 = segments 2..N are timed by counter, 0 = each segment needs its own trigger
seg_done_i  in  1  one-cycle pulse from capture logic: current segment finished
capture_go_o  out  1  one-cycle capture-start pulse
armed_o  out  1  high while in ARMED state
capture_active_o  out  1  high from first capture_go_o until DONE or disarm
done_o  out  1  high in DONE state
segment_count_o  out  pSEG_W  capture_go_o pulses issued since arm
trigger_length  out  32  duration of the firing trigger, in cycles

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0; edge-detect history regs 0. Reset mid-operation aborts immediately with no further pulses.
- Active trigger definition: act = trig_in XNOR trigger_mode.
- Trigger event: act=1 with act_d=0, OR trigger_now=1 with trigger_now_d=0. Both edges on the same cycle form a single event. History regs update every cycle in every state.
- Disarm: cmd_arm_adc=0 in any state other than IDLE -> IDLE next cycle. No pulse is issued on that cycle or later. trigger_length and segment_count_o hold their values.
- IDLE -> on cmd_arm_adc=1:
  - Clear segment_count_o and trigger_length.
  - If trigger_wait=1 and act=1, go to WAIT_INACTIVE; otherwise go to ARMED.
- WAIT_INACTIVE: on act=0, go to ARMED. An edge on the same cycle is not an event.
- ARMED: on an event at cycle T:
  - Load offset counter with trigger_offset; go to OFFSET.
  - Start the length measurement (first segment only).
- OFFSET:
  - If counter==0: capture_go_o=1 this cycle, increment segment_count_o, go to SEG_BUSY.
  - Else: decrement the counter.
  - Net timing: capture_go_o is high exactly in cycle T+1+trigger_offset. Offset 0 gives go at T+1.
  - trigger_offset is sampled at the event; later changes are ignored.
- SEG_BUSY, when segment_count_o == max(num_segments,1): on seg_done_i go to DONE.
- SEG_BUSY, trigger mode (segment_cycle_counter_en=0): on seg_done_i go to ARMED. Events during SEG_BUSY are discarded.
- SEG_BUSY, counter mode (segment_cycle_counter_en=1):
  - Inter-segment counter is loaded with max(segment_cycles,1)-1 on each go pulse and decrements each cycle.
  - At 0: capture_go_o=1 and segment_count_o increments.
  - Result: successive go pulses are exactly max(segment_cycles,1) cycles apart. seg_done_i is ignored except on the final segment.
  - trigger_offset is not applied to counter-timed segments.
- DONE: done_o=1; hold until cmd_arm_adc=0, then go to IDLE.
- capture_active_o: set together with the first capture_go_o; cleared on entry to DONE or IDLE.
- trigger_length:
  - Counts +1 per cycle starting at cycle T while act=1; the event cycle counts as 1.
  - Stops permanently on the first act=0. Saturates at 32'hFFFF_FFFF.
  - If the event came from trigger_now with act=0, the value stays 0.
  - Not restarted by later segment triggers.
- segment_count_o saturates at all-ones; it does not wrap.

Test Plan:
- Basic single-segment capture: mode=1, offset=0, num_segments=1; arm, then trig_in rises at cycle T and stays high 5 cycles. Expect capture_go_o at T+1 only, trigger_length=5, then seg_done_i -> done_o=1; deassert arm -> all status back to IDLE values.
- Offset and polarity: mode=0, offset=100; trig_in falls at T. Expect exactly one capture_go_o at T+101 and none elsewhere; a trigger_offset change at T+10 has no effect.
- trigger_wait: arm while act=1 with trigger_wait=1. Expect no arming until act=0 for one cycle; the next edge fires. With trigger_wait=0 under the same stimulus, no event occurs until act falls and rises again.
- Counter-mode segments: num_segments=4, segment_cycles=50, counter_en=1, offset=3; trigger at T. Expect go pulses at T+4, T+54, T+104, T+154, segment_count_o=4, DONE after the final seg_done_i. Repeat with segment_cycles=0 and expect spacing of 1.
- Trigger-mode segments: num_segments=3, counter_en=0. A trigger edge during SEG_BUSY is ignored; an edge after seg_done_i fires. Expect exactly 3 pulses; trigger_now plus a simultaneous trig_in edge produces one pulse.
- Abort: deassert arm in OFFSET with counter=20. Expect no capture_go_o, IDLE next cycle, trigger_length held. Assert reset_i in SEG_BUSY and expect all outputs 0 on the next cycle.

Source files
------------

// File: rtl/adc_trigger_sequencer.sv
// Trigger qualification, offset delay and per-segment capture-start sequencing in the ADC sample clock domain.
// Latency: capture_go_o fires trigger_offset+1 cycles after the qualifying edge; later segments follow by counter or by re-trigger.
// Backpressure: none; seg_done_i paces trigger-mode segments and ends the final one, and deasserting cmd_arm_adc aborts at once.
module adc_trigger_sequencer #(
    parameter int pSEG_W = 16,
    parameter int pCYC_W = 20
) (
    input  logic              adc_sampleclk,
    input  logic              reset_i,
    input  logic              cmd_arm_adc,
    input  logic              trig_in,
    input  logic              trigger_mode,
    input  logic              trigger_wait,
    input  logic              trigger_now,
    input  logic [31:0]       trigger_offset,
    input  logic [pSEG_W-1:0] num_segments,
    input  logic [pCYC_W-1:0] segment_cycles,
    input  logic              segment_cycle_counter_en,
    input  logic              seg_done_i,
    output logic              capture_go_o,
    output logic              armed_o,
    output logic              capture_active_o,
    output logic              done_o,
    output logic [pSEG_W-1:0] segment_count_o,
    output logic [31:0]       trigger_length
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_INACTIVE,
        S_ARMED,
        S_OFFSET,
        S_SEG_BUSY,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic              act, act_d, now_d, trig_evt;
    logic [31:0]       off_cnt;
    logic [pCYC_W-1:0] gap_cnt, gap_load;
    logic [pSEG_W-1:0] seg_target;
    logic              last_seg, go, active_r, len_run, len_start, arm_clear;

    assign act       = ~(trig_in ^ trigger_mode);
    assign trig_evt  = (act & ~act_d) | (trigger_now & ~now_d);
    assign seg_target = (num_segments == '0) ? pSEG_W'(1) : num_segments;
    assign last_seg  = (segment_count_o >= seg_target);
    // Loading spacing-1 on the go cycle makes pulses exactly max(segment_cycles,1) apart.
    assign gap_load  = (segment_cycles == '0) ? '0 : segment_cycles - pCYC_W'(1);
    assign arm_clear = (state == S_IDLE) && cmd_arm_adc;
    assign len_start = (state == S_ARMED) && (state_nxt == S_OFFSET) && (segment_count_o == '0);

    always_ff @(posedge adc_sampleclk) begin
        if (reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state != S_IDLE && !cmd_arm_adc) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_arm_adc) begin
                        state_nxt = (trigger_wait && act) ? S_WAIT_INACTIVE : S_ARMED;
                    end
                end
                S_WAIT_INACTIVE: begin
                    if (!act) begin
                        state_nxt = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (trig_evt) begin
                        state_nxt = S_OFFSET;
                    end
                end
                S_OFFSET: begin
                    if (off_cnt == '0) begin
                        state_nxt = S_SEG_BUSY;
                    end
                end
                S_SEG_BUSY: begin
                    if (last_seg) begin
                        if (seg_done_i) begin
                            state_nxt = S_DONE;
                        end
                    end else if (!segment_cycle_counter_en && seg_done_i) begin
                        state_nxt = S_ARMED;
                    end
                end
                S_DONE:  state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        go = 1'b0;
        if (cmd_arm_adc) begin
            if (state == S_OFFSET && off_cnt == '0) begin
                go = 1'b1;
            end else if (state == S_SEG_BUSY && !last_seg && segment_cycle_counter_en && gap_cnt == '0) begin
                go = 1'b1;
            end
        end
        capture_go_o     = go;
        armed_o          = (state == S_ARMED);
        done_o           = (state == S_DONE);
        capture_active_o = active_r | go;
    end

    always_ff @(posedge adc_sampleclk) begin
        if (reset_i) begin
            act_d           <= 1'b0;
            now_d           <= 1'b0;
            off_cnt         <= '0;
            gap_cnt         <= '0;
            active_r        <= 1'b0;
            len_run         <= 1'b0;
            segment_count_o <= '0;
            trigger_length  <= '0;
        end else begin
            act_d <= act;
            now_d <= trigger_now;

            if (state == S_ARMED && state_nxt == S_OFFSET) begin
                off_cnt <= trigger_offset;
            end else if (state == S_OFFSET && off_cnt != '0) begin
                off_cnt <= off_cnt - 32'd1;
            end

            if (go) begin
                gap_cnt <= gap_load;
            end else if (state == S_SEG_BUSY && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - pCYC_W'(1);
            end

            if (arm_clear) begin
                segment_count_o <= '0;
            end else if (go && segment_count_o != '1) begin
                segment_count_o <= segment_count_o + pSEG_W'(1);
            end

            if (state_nxt == S_DONE || state_nxt == S_IDLE) begin
                active_r <= 1'b0;
            end else if (go) begin
                active_r <= 1'b1;
            end

            // Length measures only the first trigger of an arm and freezes on the first inactive cycle.
            if (arm_clear) begin
                trigger_length <= '0;
                len_run        <= 1'b0;
            end else if (len_start) begin
                trigger_length <= {31'd0, act};
                len_run        <= act;
            end else if (len_run) begin
                if (!act || state_nxt == S_IDLE) begin
                    len_run <= 1'b0;
                end else if (trigger_length != '1) begin
                    trigger_length <= trigger_length + 32'd1;
                end
            end
        end
    end

endmodule
